// File: rtl/div_seq_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_seq_param_if : start/busy/done handshake and operand/result bus
//                    for div_seq_param (is_unsigned only with DIV_UNSIGNED_EN)
// Revision 1.0
// ---------------------------------------------------------------------------
interface div_seq_param_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [WIDTH-1:0] i_op_a;
  logic [WIDTH-1:0] i_op_b;
`ifdef DIV_UNSIGNED_EN
  logic             i_is_unsigned;
`endif
  logic             o_busy;
  logic             o_done;
  logic             o_zero_div;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

`ifdef DIV_UNSIGNED_EN
  modport master (
    output i_start, i_op_a, i_op_b, i_is_unsigned,
    input  o_busy, o_done, o_zero_div, o_hi, o_lo
  );
  modport slave (
    input  i_start, i_op_a, i_op_b, i_is_unsigned,
    output o_busy, o_done, o_zero_div, o_hi, o_lo
  );
`else
  modport master (
    output i_start, i_op_a, i_op_b,
    input  o_busy, o_done, o_zero_div, o_hi, o_lo
  );
  modport slave (
    input  i_start, i_op_a, i_op_b,
    output o_busy, o_done, o_zero_div, o_hi, o_lo
  );
`endif
endinterface
`default_nettype wire

// File: rtl/div_seq_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_seq_param : radix-2 restoring divider, fixed WIDTH+2 cycle latency,
//                 quotient on lo, remainder on hi. Option macro: DIV_UNSIGNED_EN
// Revision 1.0
// ---------------------------------------------------------------------------
module div_seq_param #(
  parameter int WIDTH = 32
) (
  input  wire logic      clk,
  input  wire logic      rst,
  div_seq_param_if.slave bus
);
  localparam int               CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
`ifdef DIV_UNSIGNED_EN
  localparam logic [WIDTH-1:0] c_DIV0 = '1;
`else
  localparam logic [WIDTH-1:0] c_DIV0 = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_sign_a;
  logic             r_neg_q;
  logic             r_busy;
  logic             r_done;
  logic             r_zero_div;

  logic             w_uns;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

`ifdef DIV_UNSIGNED_EN
  assign w_uns = bus.i_is_unsigned;
`else
  assign w_uns = 1'b0;
`endif

  // Negating MIN yields MIN, which is the correct magnitude read as unsigned.
  assign w_sa    = ~w_uns & bus.i_op_a[WIDTH-1];
  assign w_sb    = ~w_uns & bus.i_op_b[WIDTH-1];
  assign w_mag_a = w_sa ? -bus.i_op_a : bus.i_op_a;
  assign w_mag_b = w_sb ? -bus.i_op_b : bus.i_op_b;

  // Dividend register doubles as the quotient shift register.
  assign w_trial = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[WIDTH];
  assign w_q_fix = r_neg_q  ? -r_dvd : r_dvd;
  assign w_r_fix = r_sign_a ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_sign_a   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_zero_div <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_sign_a <= w_sa;
            r_neg_q  <= w_sa ^ w_sb;
            r_dvd    <= w_mag_a;
            r_dvs    <= w_mag_b;
            r_rem    <= '0;
            r_cnt    <= c_CNT_INIT;
            if (bus.i_op_b == '0) begin
              r_zero_div <= 1'b1;
              r_hi       <= c_DIV0;
              r_lo       <= c_DIV0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_zero_div <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_hi    <= w_r_fix;
          r_lo    <= w_q_fix;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
  assign bus.o_zero_div = r_zero_div;
  assign bus.o_hi       = r_hi;
  assign bus.o_lo       = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_div_seq_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_div_seq_param : directed and randomized bench for div_seq_param against
//                    a cycle-level arithmetic reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_div_seq_param;
  localparam int W = 32;
`ifdef DIV_UNSIGNED_EN
  localparam logic [W-1:0] c_DIV0 = 32'hFFFF_FFFF;
`else
  localparam logic [W-1:0] c_DIV0 = 32'h7FFF_FFFF;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_seq_param_if #(.WIDTH(W)) bus ();
  div_seq_param #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Quotient truncates toward zero, remainder takes the dividend's sign.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit zd);
    longint sa, sb;
    zd = (b == '0);
    if (zd) begin
      q = c_DIV0;
      r = c_DIV0;
    end else if (uns) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end
  endfunction

  function automatic bit uns_now();
`ifdef DIV_UNSIGNED_EN
    return bus.i_is_unsigned;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: m_p is the cycle index since acceptance (0 = idle).
  int           m_p = 0;
  int           m_d = 0;
  bit           m_valid = 0;
  bit           m_zd;
  logic [W-1:0] m_q, m_r;
  logic [W-1:0] e_hi = '0, e_lo = '0;
  bit           e_zd = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_p = 0; m_d = 0; e_hi = '0; e_lo = '0; e_zd = 0; m_valid = 1;
    end else if (m_p == 0) begin
      if (bus.i_start) begin
        ref_div(bus.i_op_a, bus.i_op_b, uns_now(), m_q, m_r, m_zd);
        e_zd = m_zd;
        m_d  = m_zd ? 1 : W + 2;
        m_p  = 1;
        if (m_p == m_d) begin e_hi = m_r; e_lo = m_q; end
      end
    end else if (m_p == m_d) begin
      m_p = 0;
    end else begin
      m_p++;
      if (m_p == m_d) begin e_hi = m_r; e_lo = m_q; end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy",     W'(bus.o_busy),     W'(m_p != 0 && m_p < m_d));
      check("done",     W'(bus.o_done),     W'(m_p != 0 && m_p == m_d));
      check("zero_div", W'(bus.o_zero_div), W'(e_zd));
      check("hi",       bus.o_hi, e_hi);
      check("lo",       bus.o_lo, e_lo);
    end
  end

  task automatic set_uns(input bit u);
`ifdef DIV_UNSIGNED_EN
    bus.i_is_unsigned = u;
`endif
  endtask

  // Pulses start in the next idle cycle and returns the cycle index of done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                        input int poke_at, output int lat);
    @(posedge clk); #1;
    bus.i_op_a = a; bus.i_op_b = b; set_uns(uns); bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_op_a = $urandom; bus.i_op_b = $urandom; set_uns(1'($urandom));
    lat = 1;
    while (!bus.o_done && lat < 100) begin
      if (lat == poke_at) bus.i_start = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      lat++;
    end
    check("done_seen", W'(bus.o_done), W'(1));
  endtask

  task automatic check_res(input string name, input logic [W-1:0] lo, input logic [W-1:0] hi,
                           input bit zd, input int lat, input int lat_exp);
    check({name, "_lo"},  bus.o_lo, lo);
    check({name, "_hi"},  bus.o_hi, hi);
    check({name, "_zd"},  W'(bus.o_zero_div), W'(zd));
    check({name, "_lat"}, W'(lat), W'(lat_exp));
  endtask

  initial begin
    logic [W-1:0] q, r, a, b;
    bit zd, u;
    int lat, dones;

    bus.i_start = 1'b0; bus.i_op_a = '0; bus.i_op_b = '0; set_uns(1'b0);

    ref_div(32'd100, 32'd7, 1'b0, q, r, zd);
    check("model_100_7_q", q, 32'd14);
    check("model_100_7_r", r, 32'd2);
    ref_div(32'hFFFF_FF9C, 32'd7, 1'b0, q, r, zd);
    check("model_m100_7_q", q, 32'hFFFF_FFF2);
    check("model_m100_7_r", r, 32'hFFFF_FFFE);
    ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r, zd);
    check("model_min_m1_q", q, 32'h8000_0000);
    check("model_min_m1_r", r, 32'd0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_hi", bus.o_hi, '0);
    check("rst_lo", bus.o_lo, '0);
    check("rst_busy_done_zd", W'({bus.o_busy, bus.o_done, bus.o_zero_div}), '0);

    run_op(32'd100, 32'd7, 1'b0, 0, lat);
    check_res("t1", 32'd14, 32'd2, 1'b0, lat, 34);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b0, 0, lat);
    check_res("t2a", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, lat, 34);
    run_op(32'd100, 32'hFFFF_FFF9, 1'b0, 0, lat);
    check_res("t2b", 32'hFFFF_FFF2, 32'd2, 1'b0, lat, 34);
    run_op(32'd7, 32'd0, 1'b0, 0, lat);
    check_res("t3a", c_DIV0, c_DIV0, 1'b1, lat, 1);
    run_op(32'd9, 32'd3, 1'b0, 0, lat);
    check_res("t3b", 32'd3, 32'd0, 1'b0, lat, 34);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, lat);
    check_res("t4", 32'h8000_0000, 32'd0, 1'b0, lat, 34);

    // Abort mid-operation: outputs clear and no done follows.
    @(posedge clk); #1;
    bus.i_op_a = 32'd100; bus.i_op_b = 32'd7; bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_hi", bus.o_hi, '0);
    check("abort_lo", bus.o_lo, '0);
    check("abort_busy", W'(bus.o_busy), '0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.o_done) dones++;
    end
    check("abort_no_done", W'(dones), '0);

    run_op(32'd100, 32'd7, 1'b0, 5, lat);
    check_res("t5_poke", 32'd14, 32'd2, 1'b0, lat, 34);

`ifdef DIV_UNSIGNED_EN
    run_op(32'hFFFF_FFFF, 32'd2, 1'b1, 0, lat);
    check_res("t6a", 32'h7FFF_FFFF, 32'd1, 1'b0, lat, 34);
    run_op(32'd5, 32'd0, 1'b1, 0, lat);
    check_res("t6b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, 1);
`endif

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = -W'($urandom_range(1, 15));
        3:       begin b = '1; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        default: b = $urandom;
      endcase
      if (b == '0 && $urandom_range(0, 1) == 1) a = '0;
      u = 1'($urandom);
      run_op(a, b, u, int'($urandom_range(0, 40)), lat);
      check("rand_lat", W'(lat), (b == '0) ? W'(1) : W'(34));
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
